// File: rtl/ram_stream_pkg.sv
// ram_stream_pkg: shared defaults, state encoding and counter sizing for the RAM stream reader
package ram_stream_pkg;
    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 32;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    function automatic int cnt_w(input int addr_w);
        return addr_w + 1;
    endfunction
endpackage

// File: rtl/ram_rd_fifo.sv
// ram_rd_fifo: small synchronous FIFO holding read words together with their last flag
module ram_rd_fifo #(
    parameter int W     = 33,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [W-1:0]           wr_data,
    input  logic                   rd_en,
    output logic [W-1:0]           head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);
    localparam int PW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic do_rd;
    assign do_rd = rd_en && !empty;
    assign empty = count == '0;
    assign full  = count == (PW+1)'(DEPTH);
    assign head  = mem[rd_ptr];
    // storage carries no reset; empty masks whatever stale words remain
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end
    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (PW+1)'(wr_en) - (PW+1)'(do_rd);
        end
    end
endmodule

// File: rtl/ram_stream_reader.sv
// ram_stream_reader: reads a word range from on-chip RAM and streams it out with last marking
module ram_stream_reader
    import ram_stream_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_chipselect,
    output logic              ram_write,
    output logic [3:0]        ram_byteenable,
    input  logic [DATA_W-1:0] ram_readdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last
);
    localparam int CW = cnt_w(ADDR_W);
    localparam int FW = $clog2(FIFO_DEPTH) + 1;
    state_t state, state_n;
    logic [CW-1:0] total, issued;
    logic [ADDR_W-1:0] addr;
    logic inflight, inflight_last, zero_done, accept, issue, pop;
    logic [FW-1:0] fifo_count;
    logic [FW:0] credit;
    logic fifo_empty, fifo_full;
    logic [DATA_W:0] head;
    assign pop            = out_valid && out_ready;
    assign credit         = {1'b0, fifo_count} + (FW+1)'(inflight) - (FW+1)'(pop);
    assign ram_address    = addr;
    assign ram_chipselect = issue;
    assign ram_write      = 1'b0;
    assign ram_byteenable = 4'hF;
    assign busy           = state != IDLE;
    assign done           = state == DONE || zero_done;
    assign out_valid      = !fifo_empty;
    assign out_data       = out_valid ? head[DATA_W-1:0] : '0;
    assign out_last       = out_valid && head[DATA_W];
    // start acceptance, credit-gated read issue and transfer completion
    always_comb begin
        state_n = state;
        accept  = 1'b0;
        issue   = 1'b0;
        case (state)
            IDLE: begin
                accept  = start && word_count != '0;
                state_n = accept ? RUN : IDLE;
            end
            RUN: begin
                issue   = issued < total && credit < (FW+1)'(FIFO_DEPTH);
                state_n = pop && out_last ? DONE : RUN;
            end
            default: state_n = IDLE;
        endcase
    end
    // state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= state_n;
    end
    // address/issue counters and the one-deep read-latency tracker
    always_ff @(posedge clk) begin
        if (reset) begin
            total         <= '0;
            issued        <= '0;
            addr          <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            zero_done     <= 1'b0;
        end else begin
            zero_done     <= state == IDLE && start && word_count == '0;
            inflight      <= issue;
            inflight_last <= issue && issued == total - CW'(1);
            if (accept) begin
                addr   <= base_addr;
                total  <= word_count;
                issued <= '0;
            end else if (issue) begin
                addr   <= addr + 1'b1;
                issued <= issued + 1'b1;
            end
        end
    end
    ram_rd_fifo #(
        .W     (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (inflight && !fifo_full),
        .wr_data ({inflight_last, ram_readdata}),
        .rd_en   (pop),
        .head    (head),
        .count   (fifo_count),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );
endmodule

// File: tb/tb_ram_stream_reader.sv
// tb_ram_stream_reader: directed tests with a transaction-level model checked every cycle
module tb_ram_stream_reader;
    localparam int AW = 10, DW = 32, CW = 11, DEPTH = 2;
    logic clk = 1'b0, reset = 1'b1, start = 1'b0, out_ready = 1'b1;
    logic [AW-1:0] base_addr = '0;
    logic [CW-1:0] word_count = '0;
    logic busy, done, ram_chipselect, ram_write, out_valid, out_last;
    logic [AW-1:0] ram_address;
    logic [3:0] ram_byteenable;
    logic [DW-1:0] ram_readdata, out_data;
    logic [DW-1:0] mem [1024];
    int n_chk = 0, n_fail = 0, cyc = 0, t0 = 0, rmode = 0;
    logic [DW:0] exp_q[$];
    logic [AW-1:0] addr_q[$];
    bit mb = 0, md = 0, hold = 0;
    logic [DW-1:0] hold_data;
    int outst = 0;
    int strobe_n = 0, beat_n = 0, last_n = 0, first_strobe = -1, first_beat = -1, done_rel = -1, done_n = 0, s8 = -1;
    logic [DW-1:0] first_data;
    logic [AW-1:0] saddr[$];

    ram_stream_reader #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .word_count(word_count),
        .busy(busy), .done(done), .ram_address(ram_address), .ram_chipselect(ram_chipselect),
        .ram_write(ram_write), .ram_byteenable(ram_byteenable), .ram_readdata(ram_readdata),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
    );

    always #5 clk = ~clk;

    // one-cycle-latency RAM
    always @(posedge clk) if (ram_chipselect && !ram_write) ram_readdata <= mem[ram_address];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // model: expected beats/addresses queued at start, checked every cycle
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            addr_q.delete();
            mb = 0; md = 0; hold = 0; outst = 0;
        end else begin
            bit acc, zs, lastpop;
            chk("busy", busy, 32'(mb));
            chk("done", done, 32'(md));
            chk("ram_write", ram_write, 0);
            chk("byteenable", ram_byteenable, 4'hF);
            if (hold) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, hold_data);
            end
            if (ram_chipselect) begin
                if (addr_q.size() == 0) chk("extra_strobe", ram_chipselect, 0);
                else chk("ram_address", ram_address, 32'(addr_q.pop_front()));
                outst++;
                strobe_n++;
                saddr.push_back(ram_address);
                if (strobe_n == 1) first_strobe = cyc - t0;
            end
            lastpop = 0;
            if (out_valid) begin
                if (exp_q.size() == 0) chk("spurious_valid", out_valid, 0);
                else begin
                    chk("out_data", out_data, exp_q[0][DW-1:0]);
                    chk("out_last", out_last, 32'(exp_q[0][DW]));
                end
                if (out_ready) begin
                    beat_n++;
                    if (beat_n == 1) begin first_beat = cyc - t0; first_data = out_data; end
                    if (out_last) last_n++;
                    if (exp_q.size() > 0) begin
                        lastpop = exp_q[0][DW];
                        void'(exp_q.pop_front());
                    end
                    outst--;
                end
            end
            chk("outstanding_le_depth", 32'(outst <= DEPTH), 1);
            if (cyc - t0 == 8) s8 = strobe_n;
            if (done) begin done_n++; done_rel = cyc - t0; end
            hold = out_valid && !out_ready;
            hold_data = out_data;
            acc = !mb && start && word_count != 0;
            zs = !mb && start && word_count == 0;
            if (acc) for (int i = 0; i < int'(word_count); i++) begin
                exp_q.push_back({i == int'(word_count) - 1, mem[(int'(base_addr) + i) % 1024]});
                addr_q.push_back(AW'(int'(base_addr) + i));
            end
            mb = acc ? 1'b1 : (md ? 1'b0 : mb);
            md = lastpop || zs;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        case (rmode)
            1: out_ready = 1'($urandom_range(0, 1));
            2: out_ready = !((cyc - t0) >= 2 && (cyc - t0) <= 8);
            default: out_ready = 1'b1;
        endcase
    endtask

    task automatic do_start(input logic [AW-1:0] b, input logic [CW-1:0] n);
        base_addr = b; word_count = n; start = 1'b1;
        t0 = cyc; strobe_n = 0; beat_n = 0; last_n = 0;
        first_strobe = -1; first_beat = -1; done_rel = -1; s8 = -1;
        saddr.delete();
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, input string name);
        int d0 = done_n;
        int k = 0;
        while (done_n == d0 && k < limit) begin tick(); k++; end
        chk({name, "_done_seen"}, 32'(done_n != d0), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int d0, k;
        for (int i = 0; i < 1024; i++) mem[i] = DW'(i) * 32'h11111111;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cs", ram_chipselect, 0);
        chk("rst_addr", ram_address, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_last", out_last, 0);
        chk("rst_data", out_data, 0);

        do_start(10'h010, 4);
        wait_done(50, "t1");
        chk("t1_first_strobe", first_strobe, 1);
        chk("t1_first_beat", first_beat, 3);
        chk("t1_first_data", first_data, 32'h11111110);
        chk("t1_done_cycle", done_rel, 7);
        chk("t1_addr0", saddr[0], 10'h010);
        chk("t1_addr3", saddr[3], 10'h013);
        chk("t1_beats", beat_n, 4);
        chk("t1_lasts", last_n, 1);

        rmode = 2;
        do_start(10'h010, 4);
        wait_done(50, "t2");
        rmode = 0;
        chk("t2_strobes_by_c8", s8, 2);
        chk("t2_beats", beat_n, 4);
        chk("t2_lasts", last_n, 1);
        chk("t2_done_cycle", done_rel, 13);

        do_start(10'h3FE, 4);
        wait_done(50, "t3");
        chk("t3_beats", beat_n, 4);
        chk("t3_addr0", saddr[0], 10'h3FE);
        chk("t3_addr1", saddr[1], 10'h3FF);
        chk("t3_addr2", saddr[2], 10'h000);
        chk("t3_addr3", saddr[3], 10'h001);

        do_start(10'h055, 0);
        wait_done(10, "t4");
        chk("t4_done_cycle", done_rel, 1);
        chk("t4_strobes", strobe_n, 0);
        tick();

        rmode = 1;
        do_start(10'h123, 1024);
        d0 = done_n;
        k = 0;
        while (done_n == d0 && k < 20000) begin
            start = (k == 50 || k == 400);
            word_count = (k == 50) ? 11'd0 : 11'd3;
            tick();
            k++;
        end
        start = 1'b0;
        chk("t5_done_seen", 32'(done_n != d0), 1);
        chk("t5_beats", beat_n, 1024);
        chk("t5_strobes", strobe_n, 1024);
        chk("t5_lasts", last_n, 1);
        rmode = 0;
        tick();

        do_start(10'h200, 10);
        k = 0;
        while (beat_n < 3 && k < 50) begin tick(); k++; end
        chk("t6_three_beats", 32'(beat_n >= 3), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_valid_after_rst", out_valid, 0);
        chk("t6_busy_after_rst", busy, 0);
        chk("t6_done_after_rst", done, 0);
        d0 = done_n;
        repeat (5) tick();
        chk("t6_no_done", done_n, d0);
        do_start(10'h020, 2);
        wait_done(50, "t6b");
        chk("t6b_beats", beat_n, 2);
        chk("t6b_lasts", last_n, 1);
        chk("t6b_addr0", saddr[0], 10'h020);
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
